// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse receive path.
// The element encoding and ASCII codes match the transmit side.
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Thresholds in dot units, compared against the saturating unit counter.
    localparam logic [2:0] LETTER_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP   = 3'd7;
    localparam logic [2:0] DASH_MIN   = 3'd2;

    localparam int unsigned MAX_ELEMS = 6;

    localparam logic [7:0] SPACE    = 8'h20;
    localparam logic [7:0] ERR_CHAR = 8'h3F;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpaceInLetter,
        StSpaceAfterLetter
    } state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse table: {len, pattern} -> ASCII for A-Z and 0-9.
// pattern bit 0 is the first element (0 = dot, 1 = dash); unused upper bits are zero.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [5:0] pattern,
    output logic [7:0] ascii,
    output logic       valid
);

    always_comb begin
        ascii = ERR_CHAR;
        valid = 1'b1;
        case ({len, pattern})
            {3'd1, 6'b000000}: ascii = "E";
            {3'd1, 6'b000001}: ascii = "T";
            {3'd2, 6'b000010}: ascii = "A";
            {3'd2, 6'b000000}: ascii = "I";
            {3'd2, 6'b000011}: ascii = "M";
            {3'd2, 6'b000001}: ascii = "N";
            {3'd3, 6'b000001}: ascii = "D";
            {3'd3, 6'b000011}: ascii = "G";
            {3'd3, 6'b000101}: ascii = "K";
            {3'd3, 6'b000111}: ascii = "O";
            {3'd3, 6'b000010}: ascii = "R";
            {3'd3, 6'b000000}: ascii = "S";
            {3'd3, 6'b000100}: ascii = "U";
            {3'd3, 6'b000110}: ascii = "W";
            {3'd4, 6'b000001}: ascii = "B";
            {3'd4, 6'b000101}: ascii = "C";
            {3'd4, 6'b000100}: ascii = "F";
            {3'd4, 6'b000000}: ascii = "H";
            {3'd4, 6'b001110}: ascii = "J";
            {3'd4, 6'b000010}: ascii = "L";
            {3'd4, 6'b000110}: ascii = "P";
            {3'd4, 6'b001011}: ascii = "Q";
            {3'd4, 6'b001000}: ascii = "V";
            {3'd4, 6'b001001}: ascii = "X";
            {3'd4, 6'b001101}: ascii = "Y";
            {3'd4, 6'b000011}: ascii = "Z";
            {3'd5, 6'b011111}: ascii = "0";
            {3'd5, 6'b011110}: ascii = "1";
            {3'd5, 6'b011100}: ascii = "2";
            {3'd5, 6'b011000}: ascii = "3";
            {3'd5, 6'b010000}: ascii = "4";
            {3'd5, 6'b000000}: ascii = "5";
            {3'd5, 6'b000001}: ascii = "6";
            {3'd5, 6'b000011}: ascii = "7";
            {3'd5, 6'b000111}: ascii = "8";
            {3'd5, 6'b001111}: ascii = "9";
            default:           valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronises the key line, times marks/spaces in dot units of K cycles
// and emits one ASCII strobe per letter and one space per word gap.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned K = 50
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       key_in,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic       char_err,
    output logic       busy
);

    localparam int unsigned PW = $clog2(K);

    logic key_m, key_s, key_prev;
    logic rise, fall, key_edge;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            key_m    <= 1'b0;
            key_s    <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_m    <= key_in;
            key_s    <= key_m;
            key_prev <= key_s;
        end
    end

    assign rise     = key_s & ~key_prev;
    assign fall     = ~key_s & key_prev;
    assign key_edge = rise | fall;

    // Timer. Restarting at 2 credits the edge cycle and its detect cycle, so an exact
    // n-unit interval from a keyer with the same K reaches n units before the next edge.
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    unit_q, unit_d;

    always_comb begin
        phase_d = phase_q;
        unit_d  = unit_q;
        if (key_edge) begin
            phase_d = PW'(2);
            unit_d  = 3'd0;
        end else if (phase_q == PW'(K - 1)) begin
            phase_d = '0;
            if (unit_q != 3'd7) begin
                unit_d = unit_q + 3'd1;
            end
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            unit_q  <= 3'd0;
        end else begin
            phase_q <= phase_d;
            unit_q  <= unit_d;
        end
    end

    // Element register and emit control.
    logic [5:0] pattern_q, pattern_d;
    logic [2:0] elem_cnt_q, elem_cnt_d;
    logic       ovf_q, ovf_d;
    logic       word_pend_q, word_pend_d;
    logic       emit_letter, emit_word;
    logic       at_letter_gap, at_word_gap;

    assign at_letter_gap = ~key_s & ~key_edge & (unit_q == LETTER_GAP);
    assign at_word_gap   = ~key_s & ~key_edge & (unit_q == WORD_GAP);

    always_comb begin
        pattern_d   = pattern_q;
        elem_cnt_d  = elem_cnt_q;
        ovf_d       = ovf_q;
        word_pend_d = word_pend_q;
        if (fall && unit_q != 3'd0) begin
            if (elem_cnt_q == 3'(MAX_ELEMS)) begin
                ovf_d = 1'b1;
            end else begin
                pattern_d[elem_cnt_q] = (unit_q >= DASH_MIN) ? DASH : DOT;
                elem_cnt_d            = elem_cnt_q + 3'd1;
            end
        end
        if (emit_letter) begin
            pattern_d   = '0;
            elem_cnt_d  = 3'd0;
            ovf_d       = 1'b0;
            word_pend_d = 1'b1;
        end
        if (emit_word) begin
            word_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pattern_q   <= '0;
            elem_cnt_q  <= 3'd0;
            ovf_q       <= 1'b0;
            word_pend_q <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            elem_cnt_q  <= elem_cnt_d;
            ovf_q       <= ovf_d;
            word_pend_q <= word_pend_d;
        end
    end

    // Emit FSM.
    state_e state_q, state_d;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise) state_d = StMark;
            end
            StMark: begin
                if (fall) state_d = StSpaceInLetter;
            end
            StSpaceInLetter: begin
                if (rise) begin
                    state_d = StMark;
                end else if (at_letter_gap) begin
                    // A glitch-only space still owes a word gap if a letter preceded it.
                    state_d = (elem_cnt_q != 3'd0 || word_pend_q) ? StSpaceAfterLetter : StIdle;
                end
            end
            StSpaceAfterLetter: begin
                if (rise) begin
                    state_d = StMark;
                end else if (at_word_gap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        emit_letter = 1'b0;
        emit_word   = 1'b0;
        unique case (state_q)
            StSpaceInLetter:    emit_letter = at_letter_gap && (elem_cnt_q != 3'd0);
            StSpaceAfterLetter: emit_word   = at_word_gap && word_pend_q;
            default: begin
                emit_letter = 1'b0;
                emit_word   = 1'b0;
            end
        endcase
    end

    // Lookup and registered character outputs.
    logic [7:0] lut_ascii;
    logic       lut_valid;

    morse_lut u_lut (
        .len     (elem_cnt_q),
        .pattern (pattern_q),
        .ascii   (lut_ascii),
        .valid   (lut_valid)
    );

    logic       char_valid_q;
    logic [7:0] char_code_q;
    logic       char_err_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            char_valid_q <= 1'b0;
            char_code_q  <= 8'h00;
            char_err_q   <= 1'b0;
        end else begin
            char_valid_q <= emit_letter | emit_word;
            if (emit_letter) begin
                char_code_q <= (lut_valid && !ovf_q) ? lut_ascii : ERR_CHAR;
                char_err_q  <= ~(lut_valid && !ovf_q);
            end else if (emit_word) begin
                char_code_q <= SPACE;
                char_err_q  <= 1'b0;
            end
        end
    end

    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign char_err   = char_err_q;
    assign busy       = (elem_cnt_q != 3'd0);

endmodule
